// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller and its counters.
package uart_rx_pkg;

    localparam int EDGE_W = 6;
    localparam int BIT_W  = 4;

    localparam logic [EDGE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [EDGE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [EDGE_W-1:0] PRESCALE_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CHECK
    } rxState_t;

    // An unsupported ratio would leave the edge counter without a sane wrap point, so it falls back to 8.
    function automatic logic [EDGE_W-1:0] legalPrescale(input logic [EDGE_W-1:0] p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
            default:                              return PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample tick counter and data-bit index counter for the UART receive controller.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_en,
    input  logic              i_bitEn,
    input  logic [EDGE_W-1:0] i_prescale,
    output logic [EDGE_W-1:0] o_edgeCnt,
    output logic [BIT_W-1:0]  o_bitCnt,
    output logic              o_endOfBit
);

    logic [EDGE_W-1:0] r_edgeCnt;
    logic [BIT_W-1:0]  r_bitCnt;

    assign o_endOfBit = i_en && (r_edgeCnt == (i_prescale - EDGE_W'(1)));
    assign o_edgeCnt  = r_edgeCnt;
    assign o_bitCnt   = r_bitCnt;

    // Dropping an enable clears its counter, so every bit and every frame starts from zero.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_edgeCnt <= '0;
            r_bitCnt  <= '0;
        end else begin
            if (!i_en || o_endOfBit) begin
                r_edgeCnt <= '0;
            end else begin
                r_edgeCnt <= r_edgeCnt + EDGE_W'(1);
            end

            if (!i_bitEn) begin
                r_bitCnt <= '0;
            end else if (o_endOfBit) begin
                r_bitCnt <= (r_bitCnt == BIT_W'(DATA_WIDTH - 1)) ? '0 : r_bitCnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: sequences start/data/parity/stop checking and reports frame status.
// Optional break detection is compiled in with `define UART_RX_BREAK_DET_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_in,
    input  logic [EDGE_W-1:0] prescale,
    input  logic              par_en,
    input  logic              strt_glitch,
    input  logic              par_err,
    input  logic              stp_err,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              strt_chk_en,
    output logic              dat_samp_en,
    output logic              deser_en,
    output logic              par_chk_en,
    output logic              stp_chk_en,
    output logic              data_valid,
    output logic              break_det
);

    rxState_t          r_state;
    logic [EDGE_W-1:0] r_prescale;
    logic              r_parEn;
    logic              r_dataValid;

    logic w_endOfBit;
    logic w_inFrame;
    logic w_abort;
    logic w_cntEn;
    logic w_bitEn;
    logic w_frameOk;
    logic w_startFrame;
    logic w_break;
    logic w_brkHold;

    assign w_inFrame = (r_state == START) || (r_state == DATA) ||
                       (r_state == PARITY) || (r_state == STOP);
    assign w_abort   = (r_state == DATA) && (edge_cnt == '0) && (bit_cnt == '0) && strt_glitch;
    assign w_cntEn   = w_inFrame && !w_abort;
    assign w_bitEn   = (r_state == DATA) && !w_abort;
    assign w_frameOk = !(r_parEn && par_err) && !stp_err;

    // A new frame may begin from IDLE or straight out of CHECK when the next start bit is already on the line.
    assign w_startFrame = !rx_in && (((r_state == IDLE) && !w_brkHold) ||
                                     ((r_state == CHECK) && !w_break));

    uart_rx_edge_bit_cnt #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_edgeBitCnt (
        .CLK        (CLK),
        .RST        (RST),
        .i_en       (w_cntEn),
        .i_bitEn    (w_bitEn),
        .i_prescale (r_prescale),
        .o_edgeCnt  (edge_cnt),
        .o_bitCnt   (bit_cnt),
        .o_endOfBit (w_endOfBit)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_prescale  <= PRESCALE_8;
            r_parEn     <= 1'b0;
            r_dataValid <= 1'b0;
        end else begin
            r_dataValid <= (r_state == CHECK) && w_frameOk && !w_break;

            if (w_startFrame) begin
                r_prescale <= legalPrescale(prescale);
                r_parEn    <= par_en;
            end

            case (r_state)
                IDLE: begin
                    if (w_startFrame) r_state <= START;
                end
                START: begin
                    if (w_endOfBit) r_state <= DATA;
                end
                DATA: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else if (w_endOfBit && (bit_cnt == BIT_W'(DATA_WIDTH - 1))) begin
                        r_state <= r_parEn ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (w_endOfBit) r_state <= STOP;
                end
                STOP: begin
                    if (w_endOfBit) r_state <= CHECK;
                end
                CHECK: begin
                    r_state <= w_startFrame ? START : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign strt_chk_en = (r_state == START);
    assign deser_en    = (r_state == DATA);
    assign par_chk_en  = (r_state == PARITY);
    assign stp_chk_en  = (r_state == STOP);
    assign dat_samp_en = w_inFrame;
    assign data_valid  = r_dataValid;

`ifdef UART_RX_BREAK_DET_EN
    logic r_allZero;
    logic r_brkHold;
    logic r_breakDet;

    assign w_break   = (r_state == CHECK) && stp_err && r_allZero;
    assign w_brkHold = r_brkHold;
    assign break_det = r_breakDet;

    // Track whether every data bit was low at mid-bit; a break then parks the FSM until the line returns high.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_allZero  <= 1'b1;
            r_brkHold  <= 1'b0;
            r_breakDet <= 1'b0;
        end else begin
            r_breakDet <= w_break;

            if (w_break) begin
                r_brkHold <= 1'b1;
            end else if (rx_in) begin
                r_brkHold <= 1'b0;
            end

            if (w_startFrame) begin
                r_allZero <= 1'b1;
            end else if ((r_state == DATA) && (edge_cnt == (r_prescale >> 1)) && rx_in) begin
                r_allZero <= 1'b0;
            end
        end
    end
`else
    assign w_break   = 1'b0;
    assign w_brkHold = 1'b0;
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames plus randomized frames against a timing model.
module tb_uart_rx_ctrl;

    localparam int W = 8;

`ifdef UART_RX_BREAK_DET_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;

    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_chk_en, dat_samp_en, deser_en, par_chk_en, stp_chk_en;
    logic       data_valid, break_det;

    logic [16:0] obs;
    int          checks = 0;
    int          failures = 0;
    int          frameNo = 0;

    uart_rx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .strt_chk_en (strt_chk_en),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .break_det   (break_det)
    );

    always #5 CLK = ~CLK;

    assign obs = {edge_cnt, bit_cnt, strt_chk_en, dat_samp_en, deser_en,
                  par_chk_en, stp_chk_en, data_valid, break_det};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Phase codes: 0 idle, 1 start bit, 2 data bits, 3 parity bit, 4 stop bit, 5 check.
    function automatic logic [16:0] mkVec(input int e, input int b, input int ph, input bit dv, input bit brk);
        logic [5:0] e6;
        logic [3:0] b4;
        e6 = 6'(e);
        b4 = 4'(b);
        return {e6, b4, ph == 1, (ph >= 1) && (ph <= 4), ph == 2, ph == 3, ph == 4, dv, brk};
    endfunction

    // Expected outputs in the cycle after the t-th clock edge, counting the edge that saw the start bit as 0.
    function automatic logic [16:0] modelAt(input int t, input int p, input bit par, input logic [7:0] data,
                                            input bit parErr, input bit stpErr, input bit glitch,
                                            input bit nextLow, input int rstAt);
        int  L;
        int  bi;
        bit  brk;
        bit  dv;
        L = p * (2 + W + int'(par));
        if (rstAt >= 0 && t > rstAt) return '0;
        if (glitch) begin
            if (t < p)  return mkVec(t, 0, 1, 1'b0, 1'b0);
            if (t == p) return mkVec(0, 0, 2, 1'b0, 1'b0);
            return '0;
        end
        if (t < L) begin
            bi = t / p;
            if (bi == 0)              return mkVec(t % p, 0, 1, 1'b0, 1'b0);
            if (bi <= W)              return mkVec(t % p, bi - 1, 2, 1'b0, 1'b0);
            if (par && bi == W + 1)   return mkVec(t % p, 0, 3, 1'b0, 1'b0);
            return mkVec(t % p, 0, 4, 1'b0, 1'b0);
        end
        if (t == L) return mkVec(0, 0, 5, 1'b0, 1'b0);
        brk = BRK && stpErr && (data == 8'h00);
        dv  = !(par && parErr) && !stpErr && !brk;
        return mkVec(0, 0, (!brk && nextLow) ? 1 : 0, dv, brk);
    endfunction

    // Serial line level to present at the k-th clock edge of a frame.
    function automatic logic lineBit(input int k, input int p, input bit par, input logic [7:0] data,
                                     input bit stpErr, input bit glitch, input bit nextLow);
        int L;
        int bi;
        if (glitch) return (k < 3) ? 1'b0 : 1'b1;
        L = p * (2 + W + int'(par));
        if (k >= L) return !nextLow;
        bi = k / p;
        if (bi == 0) return 1'b0;
        if (bi <= W) return data[bi - 1];
        if (par && bi == W + 1) return ^data;
        return !stpErr;
    endfunction

    function automatic int randPrescale();
        case ($urandom % 3)
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    // Drives one frame and checks every cycle; a chained frame's start edge was consumed by the previous call.
    task automatic applyStimulus(input logic [7:0] data, input int p, input bit par, input bit parErr,
                                 input bit stpErr, input bit glitch, input bit nextLow,
                                 input bit chained, input int rstAt);
        int L;
        int last;
        int t0;
        L    = p * (2 + W + int'(par));
        last = (rstAt >= 0) ? rstAt + 1 : (glitch ? p + 1 : L + 1);
        frameNo++;
        if (!chained) begin
            @(negedge CLK);
            prescale = 6'(p);
            par_en   = par;
            rx_in    = 1'b0;
        end
        par_err     = parErr;
        stp_err     = stpErr;
        strt_glitch = glitch;
        t0 = chained ? 1 : 0;
        for (int t = t0; t <= last; t++) begin
            @(posedge CLK);
            @(negedge CLK);
            checkOutput($sformatf("f%0d_t%0d", frameNo, t), 32'(obs),
                        32'(modelAt(t, p, par, data, parErr, stpErr, glitch, nextLow, rstAt)));
            if (rstAt >= 0 && t >= rstAt) begin
                rx_in = 1'b1;
                RST   = (t == rstAt) ? 1'b0 : 1'b1;
            end else begin
                rx_in = lineBit(t + 1, p, par, data, stpErr, glitch, nextLow);
            end
            if (t + 1 < L - 1) begin
                prescale = 6'(randPrescale());
                par_en   = 1'($urandom);
            end else begin
                prescale = 6'(p);
                par_en   = par;
            end
        end
        strt_glitch = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  p, prevP;
        bit  par, prevPar, parErr, stpErr, nextLow, prevNext;
        logic [7:0] data;

        RST   = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_idle", 32'(obs), 32'h0);
        rx_in = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_holds_low_line", 32'(obs), 32'h0);
        rx_in = 1'b1;
        RST   = 1'b1;
        @(negedge CLK);
        checkOutput("idle_after_reset", 32'(obs), 32'h0);

        applyStimulus(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        applyStimulus(8'hC3, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        applyStimulus(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        applyStimulus(8'h12, 32, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5 * 32);
        applyStimulus(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

`ifdef UART_RX_BREAK_DET_EN
        applyStimulus(8'h00, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        repeat (20 * 16 - (16 * 10 + 2)) begin
            @(posedge CLK);
            @(negedge CLK);
            checkOutput("break_hold", 32'(obs), 32'h0);
        end
        rx_in = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
            checkOutput("break_release", 32'(obs), 32'h0);
        end
`else
        applyStimulus(8'h00, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
`endif
        applyStimulus(8'h81, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        prevNext = 1'b0;
        prevP    = 8;
        prevPar  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            p      = prevNext ? prevP : randPrescale();
            par    = prevNext ? prevPar : 1'($urandom);
            data   = 8'($urandom);
            if ($urandom % 6 == 0) data = 8'h00;
            parErr = ($urandom % 4 == 0);
            stpErr = ($urandom % 5 == 0);
            nextLow = ($urandom % 3 == 0) && !(stpErr && data == 8'h00) && (i < 9);
            applyStimulus(data, p, par, parErr, stpErr, 1'b0, nextLow, prevNext, -1);
            prevNext = nextLow;
            prevP    = p;
            prevPar  = par;
        end

        repeat (2) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
